// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment encoder/decoder pair.
// Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seven_seg_pkg;

  // Pattern driven for a blank digit; never decodes to a value.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit positions inside the err pulse vector.
  localparam int ERR_PATTERN = 0;
  localparam int ERR_SELECT  = 1;

  // Hex value -> segment pattern, identical to the encoder's table.
  localparam logic [6:0] SEG_CODE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational reverse lookup of a 7-segment pattern into its hex nibble.
// hit is set only on an exact match against SEG_CODE; the blank pattern
// is not in the table and therefore never hits.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  // Scan the shared code table; table entries are distinct so at most one matches.
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Capture front-end for a multiplexed active-low 7-segment display bus.
// Synchronizes segments and digit select, waits for the pair to hold still
// for STABLE_CYCLES consecutive samples, then commits the decoded nibble
// into a shadow frame. Once every digit has been committed the shadow is
// published on value_out with a one-cycle frame_done pulse.
//
// Pipeline timing: an input settled before edge t is in the sync stage 2
// register after edge t+1; the first matching comparison happens at edge
// t+3, so the counter reaches STABLE_CYCLES (and the commit lands) at edge
// t+STABLE_CYCLES+2. frame_done follows one edge later.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic [1:0]              err,
  output logic [3:0]              err_digit
);

  // Counter value at which a run is considered stable, and the value one
  // below it: a commit fires only on the step into saturation.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Input synchronizer and previous-sample stage
  // ---------------------------------------------------------------------
  logic [6:0]            seg_s1;
  logic [6:0]            seg_s2;
  logic [6:0]            seg_prev;
  logic [NUM_DIGITS-1:0] sel_s1;
  logic [NUM_DIGITS-1:0] sel_s2;
  logic [NUM_DIGITS-1:0] sel_prev;

  // Two-flop synchronizer plus the sample held for run comparison; reset to
  // the idle bus state (all segments dark, no digit selected).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1   <= SEG_BLANK;
      seg_s2   <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
      sel_s1   <= '0;
      sel_s2   <= '0;
      sel_prev <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= dig_sel;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
    end
  end

  // ---------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------
  logic             same;
  logic             commit;
  logic [CNT_W-1:0] stab_cnt;

  // A commit needs the current sample to extend a run that has already
  // matched STABLE_CYCLES-1 times; clear cancels it outright.
  always_comb begin
    same   = (seg_s2 == seg_prev) && (sel_s2 == sel_prev);
    commit = same && (stab_cnt == CNT_PRE) && !clear;
  end

  // Run-length counter: grows while the sample repeats, saturates so the
  // commit cannot refire, and restarts on any change or on clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stab_cnt <= '0;
    end else if (clear || !same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CNT_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Pattern decode and select classification
  // ---------------------------------------------------------------------
  logic       dec_hit;
  logic [3:0] dec_nibble;

  seven_seg_pattern_decode u_decode (
    .pattern (seg_s2),
    .hit     (dec_hit),
    .nibble  (dec_nibble)
  );

  logic       sel_onehot;
  logic       sel_multi;
  logic [3:0] sel_idx;

  // Classify the synchronized select; sel_idx is only meaningful when one-hot.
  always_comb begin
    sel_onehot = ($countones(sel_s2) == 1);
    sel_multi  = ($countones(sel_s2) > 1);
    sel_idx    = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_s2[i]) begin
        sel_idx = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame assembly
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0][3:0] shadow_next;
  logic [NUM_DIGITS-1:0]      valid_base;
  logic [NUM_DIGITS-1:0]      valid_next;
  logic                       frame_pend;
  logic                       frame_full;
  logic                       do_write;
  logic                       do_perr;
  logic                       do_serr;
  logic [1:0]                 err_next;

  // Commit outcome, shadow/mask update and frame-full detection. The mask
  // clear of a completing frame is applied first, so a commit landing in
  // that cycle already belongs to the next frame. The one-hot select itself
  // serves as the per-digit write mask.
  always_comb begin
    do_write = commit && sel_onehot && dec_hit;
    do_perr  = commit && sel_onehot && !dec_hit && (seg_s2 != SEG_BLANK);
    do_serr  = commit && sel_multi;

    err_next              = 2'b00;
    err_next[ERR_PATTERN] = do_perr;
    err_next[ERR_SELECT]  = do_serr;

    valid_base  = frame_pend ? '0 : digit_valid;
    valid_next  = valid_base;
    shadow_next = shadow;

    if (do_write) begin
      valid_next = valid_base | sel_s2;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_s2[i]) begin
          shadow_next[i] = dec_nibble;
        end
      end
    end else if (do_perr) begin
      valid_next = valid_base & ~sel_s2;
    end

    frame_full = do_write && (valid_next == '1);
  end

  // Frame state and output registers. frame_pend marks the cycle after the
  // last digit landed; on the following edge the shadow is published and the
  // mask (already cleared via valid_base) starts the next frame. clear wipes
  // the frame in progress but leaves the published frame and err_digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      digit_valid <= '0;
      frame_pend  <= 1'b0;
      frame_done  <= 1'b0;
      value_out   <= '0;
      err         <= 2'b00;
      err_digit   <= 4'h0;
    end else if (clear) begin
      shadow      <= '0;
      digit_valid <= '0;
      frame_pend  <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 2'b00;
    end else begin
      shadow      <= shadow_next;
      digit_valid <= valid_next;
      frame_pend  <= frame_full;
      frame_done  <= frame_pend;
      err         <= err_next;
      if (frame_pend) begin
        value_out <= shadow;
      end
      if (do_perr) begin
        err_digit <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder (4 digits, 4-sample stability).
// Stimulus is a sequence of held bus values. Holds of at most STABLE_CYCLES
// cycles are glitches and must leave no trace; holds of STABLE_CYCLES+5 or
// more are fully settled when they end, so the reference model applies the
// commit rules to them and all observable state is compared at that point.
// Pulse outputs are counted every cycle and compared as running totals.
module tb_seven_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int LONG_MIN = SC + 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [6:0]      seg_in;
  logic [ND-1:0]   dig_sel;
  logic            clear;
  logic [4*ND-1:0] value_out;
  logic [ND-1:0]   digit_valid;
  logic            frame_done;
  logic [1:0]      err;
  logic [3:0]      err_digit;

  seven_seg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .clear       (clear),
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err),
    .err_digit   (err_digit)
  );

  // Clock and counters
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: display code table and the expected frame state.
  logic [6:0] code_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [3:0]  m_sh [ND];
  logic [ND-1:0] m_valid;
  logic [15:0] m_value;
  logic [3:0]  m_errdig;
  int m_frames = 0, m_e0 = 0, m_e1 = 0;
  int n_frames = 0, n_e0 = 0, n_e1 = 0;
  logic [ND-1:0] last_sel;
  logic [6:0]    last_seg;

  // Pulse monitor: every cycle a pulse is high counts once.
  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) n_frames++;
    if (err[0] === 1'b1) n_e0++;
    if (err[1] === 1'b1) n_e1++;
  end

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_sh[i] = 4'h0;
    m_valid  = '0;
    m_value  = '0;
    m_errdig = '0;
  endtask

  // One settled display value: what the capture logic should make of it.
  task automatic model_apply(input logic [ND-1:0] sel, input logic [6:0] seg);
    int k;
    int v;
    if ($countones(sel) == 0) return;
    if ($countones(sel) > 1) begin
      m_e1++;
      return;
    end
    k = 0;
    for (int i = 0; i < ND; i++) if (sel[i]) k = i;
    if (seg == 7'h7F) return;
    v = -1;
    for (int i = 0; i < 16; i++) if (code_tab[i] == seg) v = i;
    if (v >= 0) begin
      m_sh[k] = 4'(v);
      m_valid[k] = 1'b1;
      if (m_valid == '1) begin
        m_value = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
        m_frames++;
        m_valid = '0;
      end
    end else begin
      m_e0++;
      m_errdig = 4'(k);
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic end_check(input string tag);
    chk({tag, ".valid"},  32'(digit_valid), 32'(m_valid));
    chk({tag, ".value"},  32'(value_out),   32'(m_value));
    chk({tag, ".errdig"}, 32'(err_digit),   32'(m_errdig));
    chk({tag, ".frames"}, n_frames, m_frames);
    chk({tag, ".err0"},   n_e0, m_e0);
    chk({tag, ".err1"},   n_e1, m_e1);
  endtask

  // Driver tasks (entered and left on a negedge).
  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg);
    dig_sel  = sel;
    seg_in   = seg;
    last_sel = sel;
    last_seg = seg;
  endtask

  task automatic hold(input string tag, input logic [ND-1:0] sel, input logic [6:0] seg, input int d);
    drive(sel, seg);
    repeat (d) @(negedge clk);
    if (d >= LONG_MIN) begin
      model_apply(sel, seg);
      end_check(tag);
    end
  endtask

  task automatic clear_pulse(input string tag);
    drive('0, 7'h7F);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < ND; i++) m_sh[i] = 4'h0;
    m_valid = '0;
    end_check(tag);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk({tag, ".value"},  32'(value_out),   32'h0);
    chk({tag, ".valid"},  32'(digit_valid), 32'h0);
    chk({tag, ".done"},   32'(frame_done),  32'h0);
    chk({tag, ".err"},    32'(err),         32'h0);
    chk({tag, ".errdig"}, 32'(err_digit),   32'h0);
    model_reset();
    @(negedge clk);
    drive('0, 7'h7F);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [ND-1:0] rsel;
    logic [6:0]    rseg;
    int            rd;

    reset_n = 1'b0;
    clear   = 1'b0;
    drive('0, 7'h7F);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.value", 32'(value_out),   32'h0);
    chk("rst.valid", 32'(digit_valid), 32'h0);
    chk("rst.done",  32'(frame_done),  32'h0);
    chk("rst.err",   32'(err),         32'h0);
    chk("rst.errdig", 32'(err_digit),  32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Digit 0 with commit latency: nothing after edge t+SC+1, set after t+SC+2.
    drive(4'b0001, 7'h30);
    repeat (SC + 2) @(negedge clk);
    chk("lat.early", 32'(digit_valid[0]), 32'h0);
    @(negedge clk);
    chk("lat.on", 32'(digit_valid[0]), 32'h1);
    repeat (3) @(negedge clk);
    model_apply(4'b0001, 7'h30);
    end_check("d0");
    hold("d1", 4'b0010, 7'h12, 10);
    hold("d2", 4'b0100, 7'h08, 10);

    // Last digit: frame_done one edge after the commit.
    drive(4'b1000, 7'h0E);
    repeat (SC + 3) @(negedge clk);
    chk("fd.early", 32'(frame_done), 32'h0);
    chk("fd.full",  32'(digit_valid), 32'hF);
    @(negedge clk);
    chk("fd.on",    32'(frame_done), 32'h1);
    chk("fd.value", 32'(value_out), 32'hFA53);
    repeat (2) @(negedge clk);
    model_apply(4'b1000, 7'h0E);
    end_check("d3");

    // Glitch rejection: 3-cycle "0" then a held "1".
    hold("g0", 4'b0001, 7'h40, 3);
    hold("g1", 4'b0001, 7'h79, 10);

    // Undecodable pattern and non-one-hot select.
    hold("perr", 4'b0100, 7'h7E, 10);
    hold("serr", 4'b0011, 7'h40, 10);

    // Clear after three digits, then a full rescan.
    hold("c0", 4'b0010, 7'h24, 10);
    hold("c1", 4'b0100, 7'h19, 10);
    clear_pulse("clr");
    hold("r0", 4'b0001, 7'h02, 10);
    hold("r1", 4'b0010, 7'h78, 10);
    hold("r2", 4'b0100, 7'h00, 10);
    hold("r3", 4'b1000, 7'h18, 10);

    // Reset mid-frame, then a full rescan.
    hold("m0", 4'b0001, 7'h03, 10);
    hold("m1", 4'b0010, 7'h46, 10);
    mid_reset("mrst");
    hold("p0", 4'b0001, 7'h21, 10);
    hold("p1", 4'b0010, 7'h06, 10);
    hold("p2", 4'b0100, 7'h0E, 10);
    hold("p3", 4'b1000, 7'h40, 10);

    // Randomized display traffic.
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) rsel = 4'b0001 << $urandom_range(0, 3);
      else if (r == 7) rsel = '0;
      else begin
        do rsel = 4'($urandom_range(0, 15)); while ($countones(rsel) < 2);
      end
      r = $urandom_range(0, 9);
      if (r < 6) rseg = code_tab[$urandom_range(0, 15)];
      else if (r < 8) rseg = 7'h7F;
      else rseg = 7'($urandom_range(0, 127));
      if (rsel == last_sel && rseg == last_seg) rseg = rseg ^ 7'h01;
      rd = ($urandom_range(0, 9) < 3) ? $urandom_range(1, SC) : $urandom_range(LONG_MIN, LONG_MIN + 6);
      hold("rnd", rsel, rseg, rd);
      if (n % 25 == 24) clear_pulse("rclr");
      if (n == 70) mid_reset("rrst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Samples a multiplexed, active-low 7-segment display bus (segments plus one-hot digit select), filters glitches and decodes each stable pattern back to its hex nibble.
- Assembles NUM_DIGITS nibbles into a frame word.
- Used for on-board loopback/self-check of display paths and as a capture front-end for external displays.

Parameters:
- NUM_DIGITS, 8: digits per frame; legal range 1..16.
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before commit; legal range 2..255.
- CNT_W, 8: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, active-low (0 = lit), asynchronous to clk.
- dig_sel  in  NUM_DIGITS  digit enables, active-high, nominally one-hot, asynchronous to clk.
- clear  in  1  synchronous clear of frame assembly state.
- value_out  out  4*NUM_DIGITS  last completed frame; digit i occupies bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digits committed in the frame currently being assembled.
- frame_done  out  1  one-cycle pulse when value_out is updated.
- err  out  2  one-cycle pulse flags: bit0 = undecodable pattern, bit1 = select not one-hot.
- err_digit  out  4  digit index of the last bit0 error; holds its value until the next bit0 error.

Behaviour:
- Reset (reset_n low, async) sets all outputs to 0, the synchronizer and previous-sample registers to seg=7'h7F / sel=0, the stability counter to 0 and the shadow frame to 0.
- Input path: 2-flop synchronizer on seg_in and dig_sel, then a previous-sample register.
- Stability counter:
  - synchronized {seg,sel} equals previous sample -> counter increments, saturating at STABLE_CYCLES;
  - otherwise the counter resets to 0.
- Commit fires exactly once per stable run, on the cycle the counter reaches STABLE_CYCLES.
- Commit timing: with input settled before edge t, commit effects are visible after edge t+STABLE_CYCLES+2.
- A run shorter than STABLE_CYCLES never commits; this is the glitch rejection.
- Commit actions by synchronized select:
  - sel == 0: no action.
  - sel has more than one bit set: err[1] pulses; shadow and mask are unchanged.
  - sel one-hot at index k, pattern == 7'h7F (blank): no action and no error.
  - sel one-hot at index k, pattern in the 16-entry table: shadow nibble k = decoded value; digit_valid[k] = 1.
  - sel one-hot at index k, any other pattern: err[0] pulses; err_digit = k; digit_valid[k] cleared; shadow nibble k unchanged.
- Decode table ({g..a}, active-low):

  | Value | Pattern | Value | Pattern |
  |-------|---------|-------|---------|
  | 0 | 40 | 8 | 00 |
  | 1 | 79 | 9 | 18 |
  | 2 | 24 | A | 08 |
  | 3 | 30 | B | 03 |
  | 4 | 19 | C | 46 |
  | 5 | 12 | D | 21 |
  | 6 | 02 | E | 06 |
  | 7 | 78 | F | 0E |

  - Exact match only. 7'h7F (blank) is excluded from the table.
- Frame completion:
  - When a commit makes digit_valid all-ones, on the next edge: value_out <= shadow, frame_done pulses for 1 cycle, digit_valid <= 0.
  - The shadow is retained.
  - A commit arriving in that same cycle is applied after the mask clear, so it counts toward the next frame.
- Re-commit of an already-valid digit overwrites its nibble; this is not an error.
- clear (sync) zeroes digit_valid, shadow and the stability counter, and suppresses any commit and frame_done in that cycle.
  - clear has priority over all other actions.
  - value_out, err_digit and the synchronizer registers are untouched.
- reset_n asserted mid-frame aborts the frame immediately; no frame_done is produced.
- err bits are pulses and may coincide with frame_done only across different cycles, never for the same commit.

Decomposition:
- Package seven_seg_pkg:
  - SEG_CODE[0:15] pattern constants (shared with the encoder);
  - SEG_BLANK = 7'h7F;
  - ERR_PATTERN = 0, ERR_SELECT = 1 bit indices.
- Sub-module seven_seg_pattern_decode: combinational 7-bit pattern -> {hit, nibble}, built from SEG_CODE.
- Synchronizer, stability filter and frame assembly stay in the top module.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=4: hold sel=0001 with seg=7'h30, then sel=0010 with 7'h12, sel=0100 with 7'h08, sel=1000 with 7'h0E, 10 cycles each -> frame_done pulses once; value_out = 16'hFA53; digit_valid returns to 0.
- sel=0001, seg=7'h40 for exactly 3 cycles, then 7'h79 for 10 cycles -> a single commit with nibble 1; no commit of 0.
- sel=0100, seg=7'h7E held -> err = 2'b01 for 1 cycle; err_digit = 2; digit_valid[2] = 0.
- sel=0011, seg=7'h40 held -> err = 2'b10 pulse; digit_valid is unchanged.
- After 3 digits have been committed, pulse clear for 1 cycle -> digit_valid = 0; value_out keeps its previous frame; a full rescan then yields frame_done.
- Assert reset_n low mid-frame, asynchronously between edges -> all outputs read 0 immediately; release, rescan a full frame -> correct value_out.
